instr_encoder: RTL and testbench
================================

Name: instr_encoder

Overview:
- Inverse of the control decoder: accepts decoded instruction fields over a valid/ready stream.
- Validates the fields, packs them into 9-bit machine code and writes the words sequentially into instruction memory.
- Sits between the test/boot loader front end and the instruction ROM write port.
- Throughput: one word per cycle. Status: done, overflow and error.

Parameters:
- ADDR_W, 8, instruction memory address width.
- DEPTH, 256, number of writable words; must satisfy DEPTH ≤ 2^ADDR_W.

Ports:
- Clk  in  1  system clock; all state changes on rising edge.
- Reset  in  1  synchronous, active-high reset.
- start  in  1  pulse: clear address and status, enter LOAD.
- in_valid  in  1  field bundle valid.
- in_ready  out  1  encoder can accept this cycle.
- in_type  in  2  Instr_Type.
- in_op  in  3  opcode (R: ALU op; M/B: low 2 bits used).
- in_sel  in  1  r0/r1 select (I dest, M short reg).
- in_reg  in  4  r0-15 field (M long reg, R dest).
- in_imm  in  6  I: imm6; B: imm[4:0] target index.
- in_last  in  1  marks final word of program.
- wr_en  out  1  instruction memory write strobe.
- wr_addr  out  ADDR_W  write address.
- wr_data  out  9  machine code.
- done  out  1  one-cycle pulse after last word written.
- overflow  out  1  sticky: memory full before in_last.
- err  out  1  sticky: at least one illegal bundle dropped.
- word_count  out  ADDR_W+1  words written since start.

Behaviour:
- Reset, all outputs 0:
  - state=IDLE.
  - in_ready=0, wr_en=0, wr_addr=0, wr_data=0.
  - done=0, overflow=0, err=0, word_count=0.
- States:
  - IDLE: in_ready=0. start → LOAD (addr=0, count=0, overflow=0, err=0).
  - LOAD: in_ready=1. Handshake = in_valid & in_ready.
  - FULL: in_ready=0, overflow=1. start → LOAD.
  - DONE: one cycle, done=1, in_ready=0, then → IDLE.
- Encoding, wr_data[8:7]=in_type:
  - I (00): [6]=in_sel, [5:0]=in_imm.
  - M (01): [6:5]=in_op[1:0], [4]=in_sel, [3:0]=in_reg.
  - R (10): [6:4]=in_op, [3:0]=in_reg.
  - B (11): [6:5]=in_op[1:0], [4:0]=in_imm[4:0].
- Illegal bundle:
  - Conditions: M or B with in_op[2]=1, or B with in_imm[5]=1.
  - Accepted but dropped: no write, address not advanced, err set sticky.
  - If in_last is also set, still go to DONE.
- Latency: handshake in cycle N → wr_en=1 in cycle N+1 with registered wr_addr/wr_data; wr_en=0 otherwise.
- After each write: addr+1, word_count+1.
- Full condition: the write lands at addr=DEPTH-1 without in_last → in_ready drops in N+1 and state=FULL. No wrap-around; addr holds at DEPTH-1.
- in_last on a legal word:
  - Written in N+1; DONE in N+1, so done pulses coincident with the final wr_en.
  - in_last at addr DEPTH-1 → DONE, not FULL.
- start while in LOAD: restart. addr=0 and status cleared next cycle. A handshake in the same cycle is ignored (start has priority) and no write is issued.
- start in IDLE/FULL/DONE: → LOAD. Reset at any point overrides everything, including a pending write.

Decomposition:
- definitions package (existing) holds:
  - Instr_Type enum (I=00, M=01, R=10, B=11).
  - M_opcodes (LDR, STR, MVA, MVS), R_opcodes, B_opcodes (BAL, BEQ, BLT, BLE).
  - New Enc_State enum (IDLE, LOAD, FULL, DONE).
- Sub-module instr_pack: combinational fields → {legal, word[8:0]}. The FSM, address counter and output registers stay in instr_encoder.

Test Plan:
- Reset then start; I-type sel=1 imm=6'h2A → wr_en one cycle later, wr_addr=0, wr_data=9'h06A.
- Stream back-to-back:
  - R op=3'b101 reg=4'h7 → 9'h157.
  - M op=01 sel=0 reg=4'h3 → 9'h0A3.
  - B op=10 imm=5'h05 with in_last → addrs 0,1,2, consecutive-cycle writes, done high with the third wr_en, word_count=3.
- Illegal M bundle with in_op=3'b100 between two legal words → legal words at addrs 0,1, err=1, word_count=2.
- DEPTH=4: five legal words, no in_last → four writes at addrs 0-3, in_ready=0 after the fourth, overflow=1, fifth never written.
- start asserted mid-stream with a simultaneous in_valid → no write that cycle, next accepted word written at addr 0, err/overflow cleared.
- Reset asserted in the cycle after a handshake → wr_en=0 next cycle, all outputs 0, state IDLE.

Source files
------------

// File: rtl/instr_encoder_pkg.sv
// Shared definitions for the instruction encoder: field enums, opcode names and FSM states.
package instr_encoder_pkg;

  typedef enum logic [1:0] {
    InstrI = 2'b00,
    InstrM = 2'b01,
    InstrR = 2'b10,
    InstrB = 2'b11
  } instr_type_e;

  typedef enum logic [1:0] {
    MLdr = 2'b00,
    MStr = 2'b01,
    MMva = 2'b10,
    MMvs = 2'b11
  } m_opcode_e;

  // R-type ALU opcodes are passed through unchanged; all eight codes are legal.
  typedef logic [2:0] r_opcode_t;

  typedef enum logic [1:0] {
    BBal = 2'b00,
    BBeq = 2'b01,
    BBlt = 2'b10,
    BBle = 2'b11
  } b_opcode_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StFull = 2'b10,
    StDone = 2'b11
  } enc_state_e;

  localparam int unsigned WordW = 9;

endpackage

// File: rtl/instr_encoder_if.sv
// Field-bundle input stream plus instruction-memory write port of the encoder.
interface instr_encoder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_type;
  logic [2:0]        in_op;
  logic              in_sel;
  logic [3:0]        in_reg;
  logic [5:0]        in_imm;
  logic              in_last;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [8:0]        wr_data;

  modport master (
    output in_valid, in_type, in_op, in_sel, in_reg, in_imm, in_last,
    input  in_ready, wr_en, wr_addr, wr_data
  );

  modport slave (
    input  in_valid, in_type, in_op, in_sel, in_reg, in_imm, in_last,
    output in_ready, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/instr_pack.sv
// Combinational packer: decoded fields to 9-bit machine code plus a legality flag.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [1:0]       in_type,
  input  logic [2:0]       in_op,
  input  logic             in_sel,
  input  logic [3:0]       in_reg,
  input  logic [5:0]       in_imm,
  output logic             legal,
  output logic [WordW-1:0] word
);

  always_comb begin
    word      = '0;
    legal     = 1'b1;
    word[8:7] = in_type;
    unique case (instr_type_e'(in_type))
      InstrI: begin
        word[6]   = in_sel;
        word[5:0] = in_imm;
      end
      InstrM: begin
        word[6:5] = in_op[1:0];
        word[4]   = in_sel;
        word[3:0] = in_reg;
        legal     = ~in_op[2];
      end
      InstrR: begin
        word[6:4] = in_op;
        word[3:0] = in_reg;
      end
      InstrB: begin
        word[6:5] = in_op[1:0];
        word[4:0] = in_imm[4:0];
        legal     = ~in_op[2] & ~in_imm[5];
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/instr_encoder.sv
// Accepts decoded instruction bundles, packs them and writes them sequentially to instruction
// memory; reports done, overflow and dropped-illegal-bundle status.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 256
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  instr_encoder_if.slave    bus,
  output logic              done,
  output logic              overflow,
  output logic              err,
  output logic [ADDR_W:0]   word_count
);

  localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

  enc_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [WordW-1:0]  wr_data_q, wr_data_d;
  logic              ovf_q, ovf_d;
  logic              err_q, err_d;

  logic             legal;
  logic [WordW-1:0] word;
  logic             at_last;

  instr_pack u_pack (
    .in_type (bus.in_type),
    .in_op   (bus.in_op),
    .in_sel  (bus.in_sel),
    .in_reg  (bus.in_reg),
    .in_imm  (bus.in_imm),
    .legal   (legal),
    .word    (word)
  );

  assign at_last = (addr_q == LastAddr);

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    count_d   = count_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    ovf_d     = ovf_q;
    err_d     = err_q;
    // start outranks any handshake presented in the same cycle
    if (start) begin
      state_d = StLoad;
      addr_d  = '0;
      count_d = '0;
      ovf_d   = 1'b0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        StLoad: begin
          if (bus.in_valid) begin
            if (legal) begin
              wr_en_d   = 1'b1;
              wr_addr_d = addr_q;
              wr_data_d = word;
              count_d   = count_q + 1'b1;
              if (!at_last) addr_d = addr_q + 1'b1;
            end else begin
              err_d = 1'b1;
            end
            if (bus.in_last) begin
              state_d = StDone;
            end else if (legal && at_last) begin
              state_d = StFull;
              ovf_d   = 1'b1;
            end
          end
        end
        StDone:  state_d = StIdle;
        StIdle:  state_d = StIdle;
        StFull:  state_d = StFull;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= StIdle;
      addr_q    <= '0;
      count_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      ovf_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      count_q   <= count_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      ovf_q     <= ovf_d;
      err_q     <= err_d;
    end
  end

  assign bus.in_ready = (state_q == StLoad);
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign done         = (state_q == StDone);
  assign overflow     = ovf_q;
  assign err          = err_q;
  assign word_count   = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: field table, directed corner sequences and a random
// stream, all checked cycle by cycle against a behavioural model.
module tb_instr_encoder;

  localparam int unsigned AW  = 3;
  localparam int unsigned DEP = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic          done;
  logic          overflow;
  logic          err;
  logic [AW:0]   word_count;

  int vectors = 0;
  int miscompares = 0;

  // Behavioural model of the encoder's visible behaviour
  bit m_load, m_full, m_done, m_err, m_wen;
  int m_addr, m_count, m_waddr, m_wdata;

  typedef struct {
    int t; int op; int sel; int rg; int imm; bit legal; int word;
  } vec_t;

  vec_t table_v[10];

  instr_encoder_if #(.ADDR_W(AW)) bus ();

  instr_encoder #(.ADDR_W(AW), .DEPTH(DEP)) dut (
    .clk        (clk),
    .reset      (reset),
    .start      (start),
    .bus        (bus),
    .done       (done),
    .overflow   (overflow),
    .err        (err),
    .word_count (word_count)
  );

  always #5 clk = ~clk;

  function automatic int enc(int t, int op, int sel, int rg, int imm);
    int w;
    case (t)
      0:       w = sel * 64 + imm % 64;
      1:       w = (op % 4) * 32 + sel * 16 + rg % 16;
      2:       w = (op % 8) * 16 + rg % 16;
      default: w = (op % 4) * 32 + imm % 32;
    endcase
    return t * 128 + w;
  endfunction

  function automatic bit is_legal(int t, int op, int imm);
    if ((t == 1 || t == 3) && op >= 4) return 1'b0;
    if (t == 3 && imm >= 32) return 1'b0;
    return 1'b1;
  endfunction

  function automatic void cmp(string nm, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic check_model();
    cmp("in_ready", int'(bus.in_ready), int'(m_load));
    cmp("wr_en", int'(bus.wr_en), int'(m_wen));
    if (m_wen) begin
      cmp("wr_addr", int'(bus.wr_addr), m_waddr);
      cmp("wr_data", int'(bus.wr_data), m_wdata);
    end
    cmp("done", int'(done), int'(m_done));
    cmp("overflow", int'(overflow), int'(m_full));
    cmp("err", int'(err), int'(m_err));
    cmp("word_count", int'(word_count), m_count);
  endtask

  // Advance the model from the current inputs, clock the DUT and check at the falling edge.
  task automatic tick();
    int t, op, imm;
    bit lg, at_end;
    t   = int'(bus.in_type);
    op  = int'(bus.in_op);
    imm = int'(bus.in_imm);
    if (reset) begin
      m_load = 0; m_full = 0; m_done = 0; m_err = 0; m_wen = 0;
      m_addr = 0; m_count = 0; m_waddr = 0; m_wdata = 0;
    end else if (start) begin
      m_load = 1; m_full = 0; m_done = 0; m_err = 0; m_wen = 0;
      m_addr = 0; m_count = 0;
    end else if (m_load && bus.in_valid) begin
      lg     = is_legal(t, op, imm);
      at_end = (m_addr == DEP - 1);
      m_wen  = lg;
      if (lg) begin
        m_waddr = m_addr;
        m_wdata = enc(t, op, int'(bus.in_sel), int'(bus.in_reg), imm);
        m_count++;
        if (!at_end) m_addr++;
      end else begin
        m_err = 1;
      end
      m_done = bus.in_last;
      if (bus.in_last) m_load = 0;
      else if (lg && at_end) begin
        m_load = 0;
        m_full = 1;
      end
    end else begin
      m_wen  = 0;
      m_done = 0;
    end
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic set_fields(int t, int op, int sel, int rg, int imm, bit last);
    bus.in_type  = 2'(t);
    bus.in_op    = 3'(op);
    bus.in_sel   = 1'(sel);
    bus.in_reg   = 4'(rg);
    bus.in_imm   = 6'(imm);
    bus.in_last  = last;
    bus.in_valid = 1'b1;
  endtask

  task automatic send(int t, int op, int sel, int rg, int imm, bit last);
    set_fields(t, op, sel, rg, imm, last);
    tick();
    bus.in_valid = 1'b0;
    bus.in_last  = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    table_v[0] = '{t: 0, op: 0, sel: 1, rg: 0,  imm: 'h2A, legal: 1, word: 'h06A};
    table_v[1] = '{t: 2, op: 5, sel: 0, rg: 7,  imm: 0,    legal: 1, word: 'h157};
    table_v[2] = '{t: 1, op: 1, sel: 0, rg: 3,  imm: 0,    legal: 1, word: 'h0A3};
    table_v[3] = '{t: 3, op: 2, sel: 0, rg: 0,  imm: 'h05, legal: 1, word: 'h1C5};
    table_v[4] = '{t: 1, op: 4, sel: 0, rg: 3,  imm: 0,    legal: 0, word: 0};
    table_v[5] = '{t: 3, op: 2, sel: 0, rg: 0,  imm: 'h25, legal: 0, word: 0};
    table_v[6] = '{t: 3, op: 6, sel: 0, rg: 0,  imm: 'h01, legal: 0, word: 0};
    table_v[7] = '{t: 2, op: 7, sel: 1, rg: 15, imm: 0,    legal: 1, word: 'h17F};
    table_v[8] = '{t: 0, op: 3, sel: 0, rg: 9,  imm: 'h3F, legal: 1, word: 'h03F};
    table_v[9] = '{t: 1, op: 3, sel: 1, rg: 10, imm: 0,    legal: 1, word: 'h0FA};

    reset = 1'b1;
    start = 1'b0;
    set_fields(0, 0, 0, 0, 0, 0);
    bus.in_valid = 1'b0;
    tick();
    tick();
    reset = 1'b0;
    cmp("rst_wr_addr", int'(bus.wr_addr), 0);
    cmp("rst_wr_data", int'(bus.wr_data), 0);
    tick();
    cmp("idle_ready", int'(bus.in_ready), 0);

    // Field table: each entry as a single-word program
    for (int i = 0; i < 10; i++) begin
      do_start();
      send(table_v[i].t, table_v[i].op, table_v[i].sel, table_v[i].rg, table_v[i].imm, 1'b1);
      cmp($sformatf("tbl%0d_wr_en", i), int'(bus.wr_en), int'(table_v[i].legal));
      if (table_v[i].legal) cmp($sformatf("tbl%0d_data", i), int'(bus.wr_data), table_v[i].word);
      cmp($sformatf("tbl%0d_done", i), int'(done), 1);
      cmp($sformatf("tbl%0d_err", i), int'(err), int'(!table_v[i].legal));
      tick();
    end

    // Back-to-back stream ending with in_last
    do_start();
    send(2, 5, 0, 7, 0, 0);
    cmp("b2b_addr0", int'(bus.wr_addr), 0);
    cmp("b2b_data0", int'(bus.wr_data), 'h157);
    send(1, 1, 0, 3, 0, 0);
    cmp("b2b_addr1", int'(bus.wr_addr), 1);
    cmp("b2b_data1", int'(bus.wr_data), 'h0A3);
    send(3, 2, 0, 0, 5, 1);
    cmp("b2b_addr2", int'(bus.wr_addr), 2);
    cmp("b2b_data2", int'(bus.wr_data), 'h1C5);
    cmp("b2b_wen2", int'(bus.wr_en), 1);
    cmp("b2b_done", int'(done), 1);
    cmp("b2b_count", int'(word_count), 3);
    tick();
    cmp("b2b_done_gone", int'(done), 0);

    // Illegal bundle between two legal words
    do_start();
    send(0, 0, 0, 0, 1, 0);
    send(1, 4, 0, 3, 0, 0);
    cmp("ill_wen", int'(bus.wr_en), 0);
    cmp("ill_err", int'(err), 1);
    send(2, 1, 0, 2, 0, 0);
    cmp("ill_addr1", int'(bus.wr_addr), 1);
    cmp("ill_count", int'(word_count), 2);

    // Fill memory without in_last; fifth word must not be written
    do_start();
    for (int i = 0; i < 5; i++) begin
      set_fields(0, 0, 0, 0, i, 0);
      tick();
      if (i < 4) cmp($sformatf("full_addr%0d", i), int'(bus.wr_addr), i);
      if (i == 3) begin
        cmp("full_ready", int'(bus.in_ready), 0);
        cmp("full_ovf", int'(overflow), 1);
      end
      if (i == 4) cmp("full_no_write", int'(bus.wr_en), 0);
    end
    bus.in_valid = 1'b0;
    tick();
    cmp("full_count", int'(word_count), 4);
    do_start();
    cmp("full_restart_ovf", int'(overflow), 0);

    // start mid-stream with a simultaneous valid word
    send(3, 7, 0, 0, 0, 0);
    send(0, 0, 1, 0, 3, 0);
    start = 1'b1;
    set_fields(2, 3, 0, 4, 0, 0);
    tick();
    start = 1'b0;
    cmp("restart_wen", int'(bus.wr_en), 0);
    cmp("restart_err", int'(err), 0);
    send(0, 0, 0, 0, 'h11, 0);
    cmp("restart_addr", int'(bus.wr_addr), 0);
    cmp("restart_data", int'(bus.wr_data), 'h011);

    // Reset in the cycle after a handshake
    send(2, 2, 0, 5, 0, 0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    cmp("rst2_wen", int'(bus.wr_en), 0);
    cmp("rst2_data", int'(bus.wr_data), 0);
    cmp("rst2_count", int'(word_count), 0);

    // Random stream
    for (int c = 0; c < 3000; c++) begin
      reset = ($urandom_range(199) == 0);
      start = ($urandom_range(29) == 0);
      set_fields(int'($urandom_range(3)), int'($urandom_range(7)), int'($urandom_range(1)),
                 int'($urandom_range(15)), int'($urandom_range(63)),
                 ($urandom_range(9) == 0));
      bus.in_valid = ($urandom_range(3) != 0);
      tick();
    end
    reset = 1'b0;
    start = 1'b0;
    bus.in_valid = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
